id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register for the 5-stage MIPS-style core.
- Captures decoded operands, register addresses and control bits, and presents them as *_dx signals to the execute stage and the forwarding unit.
- Owns load-use hazard detection: stalls fetch/decode and injects a bubble.
- Applies branch-flush squashing and write-back-to-decode operand bypass.
- Keeps a saturating stall counter for performance monitoring.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_hazard_detect.sv | 23 ++
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the decode/execute boundary: default widths,
// the decoded control-bit bundle and the ALU operation encodings.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int ALUOP_W_DEF = 4;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [ALUOP_W_DEF-1:0] ALU_AND = 4'h0;
    localparam logic [ALUOP_W_DEF-1:0] ALU_OR  = 4'h1;
    localparam logic [ALUOP_W_DEF-1:0] ALU_ADD = 4'h2;
    localparam logic [ALUOP_W_DEF-1:0] ALU_SUB = 4'h6;
    localparam logic [ALUOP_W_DEF-1:0] ALU_SLT = 4'h7;
    localparam logic [ALUOP_W_DEF-1:0] ALU_NOR = 4'hC;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: stalls decode when the load now in execute
// writes a register that the decode instruction reads.
module id_ex_stage_hazard_detect #(
    parameter int ADDR_W = 5
) (
    input  logic              valid_fd,
    input  logic [ADDR_W-1:0] rs_addr_fd,
    input  logic [ADDR_W-1:0] rt_addr_fd,
    input  logic              mem_read_dx,
    input  logic [ADDR_W-1:0] write_reg_addr_dx,
    input  logic              flush_dx,
    output logic              stall_fd
);

    logic src_match;

    // Both sources are compared unconditionally; false stalls are accepted.
    assign src_match = (write_reg_addr_dx == rs_addr_fd) || (write_reg_addr_dx == rt_addr_fd);

    assign stall_fd = valid_fd && mem_read_dx && (write_reg_addr_dx != '0)
                      && src_match && !flush_dx;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, inserts
// bubbles on flush or load-use stall, bypasses write-back data into operands.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_fd,
    input  logic [DATA_W-1:0]  pc_plus4_fd,
    input  logic [ADDR_W-1:0]  rs_addr_fd,
    input  logic [ADDR_W-1:0]  rt_addr_fd,
    input  logic [ADDR_W-1:0]  rd_addr_fd,
    input  logic [DATA_W-1:0]  rs_data_fd,
    input  logic [DATA_W-1:0]  rt_data_fd,
    input  logic [DATA_W-1:0]  imm_fd,
    input  logic               reg_write_fd,
    input  logic               mem_read_fd,
    input  logic               mem_write_fd,
    input  logic               mem_to_reg_fd,
    input  logic               alu_src_fd,
    input  logic               reg_dst_fd,
    input  logic [ALUOP_W-1:0] alu_op_fd,
    input  logic               write_reg_mw,
    input  logic [ADDR_W-1:0]  write_reg_addr_mw,
    input  logic [DATA_W-1:0]  write_data_mw,
    input  logic               flush_dx,
    output logic               stall_fd,
    output logic               valid_dx,
    output logic [DATA_W-1:0]  pc_plus4_dx,
    output logic [DATA_W-1:0]  rs_data_dx,
    output logic [DATA_W-1:0]  rt_data_dx,
    output logic [DATA_W-1:0]  imm_dx,
    output logic [ADDR_W-1:0]  rs_addr_dx,
    output logic [ADDR_W-1:0]  rt_addr_dx,
    output logic [ADDR_W-1:0]  write_reg_addr_dx,
    output logic               reg_write_dx,
    output logic               mem_read_dx,
    output logic               mem_write_dx,
    output logic               mem_to_reg_dx,
    output logic               alu_src_dx,
    output logic [ALUOP_W-1:0] alu_op_dx,
    output logic [CNT_W-1:0]   stall_count
);

    ctrl_t              ctrl_fd;
    ctrl_t              ctrl_cap;
    logic               wb_hit_rs;
    logic               wb_hit_rt;
    logic [DATA_W-1:0]  rs_byp;
    logic [DATA_W-1:0]  rt_byp;
    logic [ADDR_W-1:0]  dest_fd;
    logic               load_bubble;

    assign ctrl_fd = '{reg_write:  reg_write_fd,
                       mem_read:   mem_read_fd,
                       mem_write:  mem_write_fd,
                       mem_to_reg: mem_to_reg_fd,
                       alu_src:    alu_src_fd,
                       reg_dst:    reg_dst_fd};

    // An invalid decode slot enters execute with all control cleared.
    assign ctrl_cap = valid_fd ? ctrl_fd : CTRL_NOP;

    assign wb_hit_rs = write_reg_mw && (write_reg_addr_mw != '0) && (write_reg_addr_mw == rs_addr_fd);
    assign wb_hit_rt = write_reg_mw && (write_reg_addr_mw != '0) && (write_reg_addr_mw == rt_addr_fd);
    assign rs_byp    = wb_hit_rs ? write_data_mw : rs_data_fd;
    assign rt_byp    = wb_hit_rt ? write_data_mw : rt_data_fd;
    assign dest_fd   = ctrl_fd.reg_dst ? rd_addr_fd : rt_addr_fd;

    assign load_bubble = flush_dx || stall_fd;

    id_ex_stage_hazard_detect #(.ADDR_W(ADDR_W)) u_hazard_detect (
        .valid_fd          (valid_fd),
        .rs_addr_fd        (rs_addr_fd),
        .rt_addr_fd        (rt_addr_fd),
        .mem_read_dx       (mem_read_dx),
        .write_reg_addr_dx (write_reg_addr_dx),
        .flush_dx          (flush_dx),
        .stall_fd          (stall_fd)
    );

    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            valid_dx          <= 1'b0;
            pc_plus4_dx       <= '0;
            rs_data_dx        <= '0;
            rt_data_dx        <= '0;
            imm_dx            <= '0;
            rs_addr_dx        <= '0;
            rt_addr_dx        <= '0;
            write_reg_addr_dx <= '0;
            reg_write_dx      <= 1'b0;
            mem_read_dx       <= 1'b0;
            mem_write_dx      <= 1'b0;
            mem_to_reg_dx     <= 1'b0;
            alu_src_dx        <= 1'b0;
            alu_op_dx         <= '0;
        end else begin
            valid_dx          <= valid_fd;
            pc_plus4_dx       <= pc_plus4_fd;
            rs_data_dx        <= rs_byp;
            rt_data_dx        <= rt_byp;
            imm_dx            <= imm_fd;
            rs_addr_dx        <= valid_fd ? rs_addr_fd : '0;
            rt_addr_dx        <= valid_fd ? rt_addr_fd : '0;
            write_reg_addr_dx <= valid_fd ? dest_fd : '0;
            reg_write_dx      <= ctrl_cap.reg_write;
            mem_read_dx       <= ctrl_cap.mem_read;
            mem_write_dx      <= ctrl_cap.mem_write;
            mem_to_reg_dx     <= ctrl_cap.mem_to_reg;
            alu_src_dx        <= ctrl_cap.alu_src;
            alu_op_dx         <= valid_fd ? alu_op_fd : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_fd && (stall_count != '1)) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table-driven capture vectors plus
// hand-written load-use, flush, reset and counter-saturation sequences.
module tb_id_ex_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 2;

    logic               clk;
    logic               rst;
    logic               valid_fd;
    logic [DATA_W-1:0]  pc_plus4_fd, rs_data_fd, rt_data_fd, imm_fd;
    logic [ADDR_W-1:0]  rs_addr_fd, rt_addr_fd, rd_addr_fd;
    logic               reg_write_fd, mem_read_fd, mem_write_fd, mem_to_reg_fd, alu_src_fd, reg_dst_fd;
    logic [ALUOP_W-1:0] alu_op_fd;
    logic               write_reg_mw;
    logic [ADDR_W-1:0]  write_reg_addr_mw;
    logic [DATA_W-1:0]  write_data_mw;
    logic               flush_dx;
    logic               stall_fd;
    logic               valid_dx;
    logic [DATA_W-1:0]  pc_plus4_dx, rs_data_dx, rt_data_dx, imm_dx;
    logic [ADDR_W-1:0]  rs_addr_dx, rt_addr_dx, write_reg_addr_dx;
    logic               reg_write_dx, mem_read_dx, mem_write_dx, mem_to_reg_dx, alu_src_dx;
    logic [ALUOP_W-1:0] alu_op_dx;
    logic [CNT_W-1:0]   stall_count;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_fd(valid_fd), .pc_plus4_fd(pc_plus4_fd),
        .rs_addr_fd(rs_addr_fd), .rt_addr_fd(rt_addr_fd), .rd_addr_fd(rd_addr_fd),
        .rs_data_fd(rs_data_fd), .rt_data_fd(rt_data_fd), .imm_fd(imm_fd),
        .reg_write_fd(reg_write_fd), .mem_read_fd(mem_read_fd), .mem_write_fd(mem_write_fd),
        .mem_to_reg_fd(mem_to_reg_fd), .alu_src_fd(alu_src_fd), .reg_dst_fd(reg_dst_fd),
        .alu_op_fd(alu_op_fd), .write_reg_mw(write_reg_mw), .write_reg_addr_mw(write_reg_addr_mw),
        .write_data_mw(write_data_mw), .flush_dx(flush_dx), .stall_fd(stall_fd),
        .valid_dx(valid_dx), .pc_plus4_dx(pc_plus4_dx), .rs_data_dx(rs_data_dx),
        .rt_data_dx(rt_data_dx), .imm_dx(imm_dx), .rs_addr_dx(rs_addr_dx), .rt_addr_dx(rt_addr_dx),
        .write_reg_addr_dx(write_reg_addr_dx), .reg_write_dx(reg_write_dx), .mem_read_dx(mem_read_dx),
        .mem_write_dx(mem_write_dx), .mem_to_reg_dx(mem_to_reg_dx), .alu_src_dx(alu_src_dx),
        .alu_op_dx(alu_op_dx), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    // e_ctrl: {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm, pc;
        logic [5:0]  ctrl;
        logic [3:0]  alu;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        flush;
        logic        e_valid;
        logic [4:0]  e_rs, e_rt, e_wr;
        logic [31:0] e_rs_data, e_rt_data, e_imm, e_pc;
        logic [4:0]  e_ctrl;
        logic [3:0]  e_alu;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] ctrl, input logic [3:0] alu);
        valid_fd = v;
        rs_addr_fd = rs; rt_addr_fd = rt; rd_addr_fd = rd;
        {reg_write_fd, mem_read_fd, mem_write_fd, mem_to_reg_fd, alu_src_fd, reg_dst_fd} = ctrl;
        alu_op_fd = alu;
        rs_data_fd = 32'h0000_0A0A; rt_data_fd = 32'h0000_0B0B;
        imm_fd = 32'h4; pc_plus4_fd = 32'h200;
        write_reg_mw = 1'b0; write_reg_addr_mw = '0; write_data_mw = '0;
        flush_dx = 1'b0;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, {31'd0, valid_dx}, 32'd0);
        chk({name, "_wr"}, {27'd0, write_reg_addr_dx}, 32'd0);
        chk({name, "_mem_read"}, {31'd0, mem_read_dx}, 32'd0);
    endtask

    // Load a lw with destination rt=dst into execute.
    task automatic issue_load(input logic [4:0] dst);
        @(negedge clk);
        drive(1'b1, 5'd1, dst, 5'd0, 6'b110110, 4'h2);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{1,3,4,5, 32'h11111111,32'h22222222,32'h10,32'h100, 6'b100001,4'h2, 0,0,0, 0,
                    1,3,4,5, 32'h11111111,32'h22222222,32'h10,32'h100, 5'b10000,4'h2};
        vecs[1] = '{1,1,9,6, 32'hA,32'hB,32'hFFFFFFFC,32'h104, 6'b100010,4'h6, 0,0,0, 0,
                    1,1,9,9, 32'hA,32'hB,32'hFFFFFFFC,32'h104, 5'b10001,4'h6};
        vecs[2] = '{1,7,2,3, 32'h0,32'h33,32'h4,32'h108, 6'b100001,4'h2, 1,7,32'hDEADBEEF, 0,
                    1,7,2,3, 32'hDEADBEEF,32'h33,32'h4,32'h108, 5'b10000,4'h2};
        vecs[3] = '{1,0,0,3, 32'h5,32'h6,32'h0,32'h10C, 6'b100001,4'h2, 1,0,32'hDEADBEEF, 0,
                    1,0,0,3, 32'h5,32'h6,32'h0,32'h10C, 5'b10000,4'h2};
        vecs[4] = '{1,13,12,0, 32'h1,32'h1,32'h8,32'h110, 6'b001010,4'h2, 1,12,32'hCAFEF00D, 0,
                    1,13,12,12, 32'h1,32'hCAFEF00D,32'h8,32'h110, 5'b00101,4'h2};
        vecs[5] = '{1,7,7,8, 32'h21,32'h22,32'h0,32'h114, 6'b100001,4'h0, 0,7,32'hDEADBEEF, 0,
                    1,7,7,8, 32'h21,32'h22,32'h0,32'h114, 5'b10000,4'h0};
        vecs[6] = '{0,3,4,5, 32'h31,32'h32,32'h33,32'h118, 6'b111111,4'hF, 0,0,0, 0,
                    0,0,0,0, 32'h31,32'h32,32'h33,32'h118, 5'b00000,4'h0};
        vecs[7] = '{1,3,4,5, 32'h41,32'h42,32'h43,32'h11C, 6'b110001,4'h2, 1,3,32'hDEADBEEF, 1,
                    0,0,0,0, 32'h0,32'h0,32'h0,32'h0, 5'b00000,4'h0};
        vecs[8] = '{1,9,9,10, 32'h1,32'h2,32'h3,32'h120, 6'b100001,4'h2, 1,9,32'h55, 0,
                    1,9,9,10, 32'h55,32'h55,32'h3,32'h120, 5'b10000,4'h2};

        // Reset with hazardous-looking inputs held for two cycles
        rst = 1'b1;
        drive(1'b1, 5'd8, 5'd8, 5'd8, 6'b111111, 4'hF);
        write_reg_mw = 1'b1; write_reg_addr_mw = 5'd8; write_data_mw = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_dx}, 32'd0);
        chk("rst_ctrl", {27'd0, reg_write_dx, mem_read_dx, mem_write_dx, mem_to_reg_dx, alu_src_dx}, 32'd0);
        chk("rst_addr", {17'd0, rs_addr_dx, rt_addr_dx, write_reg_addr_dx}, 32'd0);
        chk("rst_data", rs_data_dx | rt_data_dx | imm_dx | pc_plus4_dx, 32'd0);
        chk("rst_alu", {28'd0, alu_op_dx}, 32'd0);
        chk("rst_stall_fd", {31'd0, stall_fd}, 32'd0);
        chk("rst_count", {30'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            valid_fd = vecs[i].valid;
            rs_addr_fd = vecs[i].rs; rt_addr_fd = vecs[i].rt; rd_addr_fd = vecs[i].rd;
            rs_data_fd = vecs[i].rs_data; rt_data_fd = vecs[i].rt_data;
            imm_fd = vecs[i].imm; pc_plus4_fd = vecs[i].pc;
            {reg_write_fd, mem_read_fd, mem_write_fd, mem_to_reg_fd, alu_src_fd, reg_dst_fd} = vecs[i].ctrl;
            alu_op_fd = vecs[i].alu;
            write_reg_mw = vecs[i].wb_en; write_reg_addr_mw = vecs[i].wb_addr; write_data_mw = vecs[i].wb_data;
            flush_dx = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_stall_fd", i), {31'd0, stall_fd}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, valid_dx}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_rs_addr", i), {27'd0, rs_addr_dx}, {27'd0, vecs[i].e_rs});
            chk($sformatf("v%0d_rt_addr", i), {27'd0, rt_addr_dx}, {27'd0, vecs[i].e_rt});
            chk($sformatf("v%0d_wr_addr", i), {27'd0, write_reg_addr_dx}, {27'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_rs_data", i), rs_data_dx, vecs[i].e_rs_data);
            chk($sformatf("v%0d_rt_data", i), rt_data_dx, vecs[i].e_rt_data);
            chk($sformatf("v%0d_imm", i), imm_dx, vecs[i].e_imm);
            chk($sformatf("v%0d_pc", i), pc_plus4_dx, vecs[i].e_pc);
            chk($sformatf("v%0d_ctrl", i),
                {27'd0, reg_write_dx, mem_read_dx, mem_write_dx, mem_to_reg_dx, alu_src_dx},
                {27'd0, vecs[i].e_ctrl});
            chk($sformatf("v%0d_alu", i), {28'd0, alu_op_dx}, {28'd0, vecs[i].e_alu});
        end

        // Load-use on rs: one stall, one bubble, then the add is captured
        issue_load(5'd8);
        chk("lu_load_mem_read", {31'd0, mem_read_dx}, 32'd1);
        chk("lu_load_wr", {27'd0, write_reg_addr_dx}, 32'd8);
        @(negedge clk);
        drive(1'b1, 5'd8, 5'd2, 5'd9, 6'b100001, 4'h2);
        #1;
        chk("lu_stall_fd", {31'd0, stall_fd}, 32'd1);
        @(posedge clk); #1;
        chk_bubble("lu_bubble");
        chk("lu_count", {30'd0, stall_count}, 32'd1);
        chk("lu_stall_released", {31'd0, stall_fd}, 32'd0);
        @(posedge clk); #1;
        chk("lu_add_valid", {31'd0, valid_dx}, 32'd1);
        chk("lu_add_wr", {27'd0, write_reg_addr_dx}, 32'd9);
        chk("lu_add_rs", {27'd0, rs_addr_dx}, 32'd8);
        chk("lu_count_hold", {30'd0, stall_count}, 32'd1);

        // Load into $0 never stalls
        issue_load(5'd0);
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 5'd9, 6'b100001, 4'h2);
        #1;
        chk("z_stall_fd", {31'd0, stall_fd}, 32'd0);
        @(posedge clk); #1;
        chk("z_add_valid", {31'd0, valid_dx}, 32'd1);
        chk("z_count", {30'd0, stall_count}, 32'd1);

        // Flush beats the hazard: bubble, no stall, count unchanged
        issue_load(5'd8);
        @(negedge clk);
        drive(1'b1, 5'd8, 5'd2, 5'd9, 6'b100001, 4'h2);
        flush_dx = 1'b1;
        #1;
        chk("fl_stall_fd", {31'd0, stall_fd}, 32'd0);
        @(posedge clk); #1;
        chk_bubble("fl_bubble");
        chk("fl_count", {30'd0, stall_count}, 32'd1);

        // Reset during a stall: counter cleared, stall drops once bubble is in
        issue_load(5'd8);
        @(negedge clk);
        drive(1'b1, 5'd3, 5'd8, 5'd9, 6'b100001, 4'h2);
        #1;
        chk("rs_stall_rt", {31'd0, stall_fd}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rs_count", {30'd0, stall_count}, 32'd0);
        chk("rs_stall_drop", {31'd0, stall_fd}, 32'd0);
        chk_bubble("rs_bubble");
        @(negedge clk);
        rst = 1'b0;

        // Saturation of the 2-bit counter across four load-use stalls
        for (int k = 1; k <= 4; k++) begin
            issue_load(5'd8);
            @(negedge clk);
            drive(1'b1, 5'd8, 5'd2, 5'd9, 6'b100001, 4'h2);
            #1;
            chk($sformatf("sat%0d_stall_fd", k), {31'd0, stall_fd}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("sat%0d_count", k), {30'd0, stall_count}, (k < 3) ? k : 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
